// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction-fetch stage, directly upstream of ID.
//
// Owns the PC, issues one-at-a-time requests on an SRAM-like instruction port,
// buffers the returned word and presents {o_pc, o_inst} to ID with a
// valid/ready handshake. Branch/jump redirects from ID are applied so that
// exactly one delay-slot instruction is fetched after the branch.
//
// Optional feature macro: IF_EXC_EN
//   defined   : misaligned fetch_pc raises o_adel instead of issuing a request
//   undefined : no alignment check, o_adel is always 0
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-low reset
//   inst_req       out  fetch request (one outstanding at most)
//   inst_addr      out  fetch address (fetch_pc)
//   inst_addr_ok   in   request accepted this cycle
//   inst_data_ok   in   read data valid this cycle
//   inst_rdata     in   instruction word
//   o_valid        out  {o_pc, o_inst} valid towards ID
//   o_pc / o_inst  out  PC and instruction handed to ID
//   id_ready       in   ID accepts the held instruction this cycle
//   br_valid       in   ID resolves its held instruction this cycle
//   pcsource       in   00 pc+4, 01 bpc, 10 jrpc, 11 jpc
//   bpc/jrpc/jpc   in   redirect targets
//   o_adel         out  fetch address error (IF_EXC_EN only)
// -----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst,
    input  logic        id_ready,
    input  logic        br_valid,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jrpc,
    input  logic [31:0] jpc,
    output logic        o_adel
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] fetch_pc_reg, fetch_pc_next;
    logic [31:0] req_pc_reg, req_pc_next;
    logic        redir_valid_reg, redir_valid_next;
    logic [31:0] redir_pc_reg, redir_pc_next;
    logic        ds_done_reg, ds_done_next;
    logic        o_valid_reg, o_valid_next;
    logic [31:0] o_pc_reg, o_pc_next;
    logic [31:0] o_inst_reg, o_inst_next;
    logic        o_adel_reg, o_adel_next;

    logic        misaligned;
    logic        req_cond;
    logic        accept;
    logic        exc_fire;
    logic        take;
    logic        br_redirect;
    logic [31:0] target;

`ifdef IF_EXC_EN
    assign misaligned = (fetch_pc_reg[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign req_cond = (state_reg == S_REQ) && !misaligned;
    // Gated by the reset pin so no request is visible while reset is held;
    // the request appears in the very first cycle after release.
    assign inst_req  = req_cond && reset;
    assign inst_addr = fetch_pc_reg;

    assign accept   = req_cond && inst_addr_ok;
    assign exc_fire = (state_reg == S_REQ) && misaligned;
    // A faulting fetch occupies the same slot in the instruction stream as an
    // accepted request, so it drives the delay-slot bookkeeping the same way.
    assign take     = accept || exc_fire;

    assign br_redirect = br_valid && (pcsource != 2'b00);

    always_comb begin
        target = bpc;
        case (pcsource)
            2'b01:   target = bpc;
            2'b10:   target = jrpc;
            2'b11:   target = jpc;
            default: target = bpc;
        endcase
    end

    always_comb begin
        state_next       = state_reg;
        fetch_pc_next    = fetch_pc_reg;
        req_pc_next      = req_pc_reg;
        redir_valid_next = redir_valid_reg;
        redir_pc_next    = redir_pc_reg;
        ds_done_next     = ds_done_reg;
        o_valid_next     = o_valid_reg;
        o_pc_next        = o_pc_reg;
        o_inst_next      = o_inst_reg;
        o_adel_next      = o_adel_reg;

        case (state_reg)
            S_REQ: begin
                if (accept) begin
                    state_next  = S_WAIT;
                    req_pc_next = fetch_pc_reg;
                end else if (exc_fire) begin
                    state_next   = S_HOLD;
                    o_valid_next = 1'b1;
                    o_adel_next  = 1'b1;
                    o_pc_next    = fetch_pc_reg;
                    o_inst_next  = 32'h0;
                end
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    state_next   = S_HOLD;
                    o_valid_next = 1'b1;
                    o_adel_next  = 1'b0;
                    o_pc_next    = req_pc_reg;
                    o_inst_next  = inst_rdata;
                end
            end
            S_HOLD: begin
                // Next request issues the cycle after handoff, so no fetch
                // runs ahead of an unresolved branch beyond its delay slot.
                if (id_ready) begin
                    state_next   = S_REQ;
                    o_valid_next = 1'b0;
                    o_adel_next  = 1'b0;
                end
            end
            default: state_next = S_REQ;
        endcase

        // ds_done: the slot after the instruction held in ID has been fetched.
        if (take) begin
            ds_done_next = 1'b1;
            if (redir_valid_reg) begin
                fetch_pc_next    = redir_pc_reg;
                redir_valid_next = 1'b0;
            end else if (accept) begin
                fetch_pc_next = fetch_pc_reg + 32'd4;
            end
        end else if (o_valid_reg && id_ready) begin
            ds_done_next = 1'b0;
        end

        // Redirect uses the pre-update ds_done: once the delay slot is out
        // (or going out this cycle) the target replaces fetch_pc directly,
        // otherwise it waits for the delay-slot acceptance.
        if (br_redirect) begin
            if (ds_done_reg || take) begin
                fetch_pc_next    = target;
                redir_valid_next = 1'b0;
            end else begin
                redir_valid_next = 1'b1;
                redir_pc_next    = target;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= S_REQ;
            fetch_pc_reg    <= RESET_PC;
            req_pc_reg      <= 32'h0;
            redir_valid_reg <= 1'b0;
            redir_pc_reg    <= 32'h0;
            ds_done_reg     <= 1'b0;
            o_valid_reg     <= 1'b0;
            o_pc_reg        <= 32'h0;
            o_inst_reg      <= 32'h0;
            o_adel_reg      <= 1'b0;
        end else begin
            state_reg       <= state_next;
            fetch_pc_reg    <= fetch_pc_next;
            req_pc_reg      <= req_pc_next;
            redir_valid_reg <= redir_valid_next;
            redir_pc_reg    <= redir_pc_next;
            ds_done_reg     <= ds_done_next;
            o_valid_reg     <= o_valid_next;
            o_pc_reg        <= o_pc_next;
            o_inst_reg      <= o_inst_next;
            o_adel_reg      <= o_adel_next;
        end
    end

    assign o_valid = o_valid_reg;
    assign o_pc    = o_pc_reg;
    assign o_inst  = o_inst_reg;
    assign o_adel  = o_adel_reg;

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage -- directed self-checking bench for if_stage.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = 32'h0;
    logic        o_valid;
    logic [31:0] o_pc;
    logic [31:0] o_inst;
    logic        id_ready = 1'b0;
    logic        br_valid = 1'b0;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = 32'h0;
    logic [31:0] jrpc = 32'h0;
    logic [31:0] jpc = 32'h0;
    logic        o_adel;

    int total = 0;
    int bad = 0;

    if_stage #(.RESET_PC(32'hbfc0_0000)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .o_valid(o_valid), .o_pc(o_pc), .o_inst(o_inst), .id_ready(id_ready),
        .br_valid(br_valid), .pcsource(pcsource),
        .bpc(bpc), .jrpc(jrpc), .jpc(jpc), .o_adel(o_adel)
    );

    always #5 clk = ~clk;

    // One fetch: wait for inst_req, accept it, return data one cycle later,
    // optionally pulsing br_valid in the data cycle. Ends in S_HOLD.
    task automatic do_fetch(input logic [31:0] rdata, input logic br_en,
                            input logic [1:0] br_src,
                            output logic [31:0] addr, output bit ok);
        ok = 1'b0;
        addr = 32'h0;
        for (int n = 0; n < 20 && !ok; n++) begin
            if (inst_req === 1'b1) begin
                ok = 1'b1;
                addr = inst_addr;
                inst_addr_ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (ok) begin
            @(negedge clk);
            inst_addr_ok = 1'b0;
            inst_data_ok = 1'b1;
            inst_rdata = rdata;
            br_valid = br_en;
            pcsource = br_src;
            @(negedge clk);
            inst_data_ok = 1'b0;
            br_valid = 1'b0;
            pcsource = 2'b00;
            $display("fetch addr=%h inst=%h o_valid=%b o_pc=%h o_inst=%h", addr, rdata, o_valid, o_pc, o_inst);
        end else begin
            $display("fetch: no inst_req within 20 cycles");
        end
    endtask

    task automatic handoff();
        id_ready = 1'b1;
        @(negedge clk);
        id_ready = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (inst_req !== 1'b0) begin bad++; $display("FAIL rst_inst_req got=%b want=0", inst_req); end
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_o_valid got=%b want=0", o_valid); end
        total++; if (o_pc !== 32'h0) begin bad++; $display("FAIL rst_o_pc got=%h want=0", o_pc); end
        total++; if (o_inst !== 32'h0) begin bad++; $display("FAIL rst_o_inst got=%h want=0", o_inst); end
        total++; if (o_adel !== 1'b0) begin bad++; $display("FAIL rst_o_adel got=%b want=0", o_adel); end
        total++; if (inst_addr !== 32'hbfc0_0000) begin bad++; $display("FAIL rst_addr got=%h want=bfc00000", inst_addr); end
        reset = 1'b1;
        #1;
        total++; if (inst_req !== 1'b1) begin bad++; $display("FAIL rst_first_req got=%b want=1", inst_req); end
        $display("reset released: inst_req=%b inst_addr=%h", inst_req, inst_addr);
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        logic [31:0] exp_a;
        logic [31:0] d;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            exp_a = 32'hbfc0_0000 + 32'(4 * i);
            d = 32'h1000_0000 + 32'(i);
            do_fetch(d, 1'b0, 2'b00, a, ok);
            total++; if (ok !== 1'b1) begin bad++; $display("FAIL seq_req_seen got=%b want=1", ok); end
            total++; if (a !== exp_a) begin bad++; $display("FAIL seq_addr got=%h want=%h", a, exp_a); end
            total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL seq_valid got=%b want=1", o_valid); end
            total++; if (o_pc !== exp_a) begin bad++; $display("FAIL seq_o_pc got=%h want=%h", o_pc, exp_a); end
            total++; if (o_inst !== d) begin bad++; $display("FAIL seq_o_inst got=%h want=%h", o_inst, d); end
            handoff();
        end
    endtask

    task automatic test_stall();
        logic [31:0] a;
        bit ok;
        do_fetch(32'h2222_000c, 1'b0, 2'b00, a, ok);
        total++; if (a !== 32'hbfc0_000c) begin bad++; $display("FAIL stall_addr got=%h want=bfc0000c", a); end
        for (int i = 0; i < 5; i++) begin
            inst_addr_ok = 1'b1;
            @(negedge clk);
            total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b want=1", o_valid); end
            total++; if (o_pc !== 32'hbfc0_000c) begin bad++; $display("FAIL stall_o_pc got=%h want=bfc0000c", o_pc); end
            total++; if (o_inst !== 32'h2222_000c) begin bad++; $display("FAIL stall_o_inst got=%h want=2222000c", o_inst); end
            total++; if (inst_req !== 1'b0) begin bad++; $display("FAIL stall_inst_req got=%b want=0", inst_req); end
        end
        inst_addr_ok = 1'b0;
        $display("stall held 5 cycles o_pc=%h", o_pc);
        handoff();
        total++; if (inst_req !== 1'b1) begin bad++; $display("FAIL stall_next_req got=%b want=1", inst_req); end
        total++; if (inst_addr !== 32'hbfc0_0010) begin bad++; $display("FAIL stall_next_addr got=%h want=bfc00010", inst_addr); end
    endtask

    task automatic test_branch_early();
        logic [31:0] a;
        bit ok;
        do_fetch(32'h1000_0040, 1'b0, 2'b00, a, ok);
        total++; if (a !== 32'hbfc0_0010) begin bad++; $display("FAIL bre_br_addr got=%h want=bfc00010", a); end
        handoff();
        // delay-slot request pending, not yet accepted: resolve branch now
        bpc = 32'hbfc0_0100;
        br_valid = 1'b1;
        pcsource = 2'b01;
        @(negedge clk);
        br_valid = 1'b0;
        pcsource = 2'b00;
        total++; if (inst_addr !== 32'hbfc0_0014) begin bad++; $display("FAIL bre_hold_addr got=%h want=bfc00014", inst_addr); end
        do_fetch(32'h0000_0000, 1'b0, 2'b00, a, ok);
        total++; if (a !== 32'hbfc0_0014) begin bad++; $display("FAIL bre_ds_addr got=%h want=bfc00014", a); end
        handoff();
        do_fetch(32'h3333_0100, 1'b0, 2'b00, a, ok);
        total++; if (a !== 32'hbfc0_0100) begin bad++; $display("FAIL bre_tgt_addr got=%h want=bfc00100", a); end
        total++; if (o_pc !== 32'hbfc0_0100) begin bad++; $display("FAIL bre_tgt_o_pc got=%h want=bfc00100", o_pc); end
        handoff();
    endtask

    task automatic test_branch_late();
        logic [31:0] a;
        logic [31:0] exp_a;
        bit ok;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            exp_a = 32'hbfc0_0000 + 32'(4 * i);
            do_fetch(32'h4444_0000 + 32'(i), 1'b0, 2'b00, a, ok);
            total++; if (a !== exp_a) begin bad++; $display("FAIL brl_pre_addr got=%h want=%h", a, exp_a); end
            handoff();
        end
        jrpc = 32'h8000_0040;
        // delay slot accepted, br_valid arrives in the following (data) cycle
        do_fetch(32'h0000_0000, 1'b1, 2'b10, a, ok);
        total++; if (a !== 32'hbfc0_0014) begin bad++; $display("FAIL brl_ds_addr got=%h want=bfc00014", a); end
        handoff();
        total++; if (inst_addr !== 32'h8000_0040) begin bad++; $display("FAIL brl_next_addr got=%h want=80000040", inst_addr); end
        do_fetch(32'h5555_0040, 1'b0, 2'b00, a, ok);
        total++; if (a !== 32'h8000_0040) begin bad++; $display("FAIL brl_tgt_addr got=%h want=80000040", a); end
        total++; if (o_inst !== 32'h5555_0040) begin bad++; $display("FAIL brl_tgt_inst got=%h want=55550040", o_inst); end
        handoff();
    endtask

    task automatic test_reset_mid();
        logic [31:0] a;
        bit ok;
        total++; if (inst_req !== 1'b1) begin bad++; $display("FAIL rmid_req got=%b want=1", inst_req); end
        inst_addr_ok = 1'b1;
        @(negedge clk);
        inst_addr_ok = 1'b0;
        // now waiting for data: reset here
        reset = 1'b0;
        #1;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid_in_rst got=%b want=0", o_valid); end
        @(negedge clk);
        reset = 1'b1;
        inst_data_ok = 1'b1;
        inst_rdata = 32'hdead_beef;
        @(negedge clk);
        inst_data_ok = 1'b0;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rmid_stale_valid got=%b want=0", o_valid); end
        total++; if (inst_req !== 1'b1) begin bad++; $display("FAIL rmid_req_after got=%b want=1", inst_req); end
        total++; if (inst_addr !== 32'hbfc0_0000) begin bad++; $display("FAIL rmid_addr got=%h want=bfc00000", inst_addr); end
        do_fetch(32'h6666_0000, 1'b0, 2'b00, a, ok);
        total++; if (a !== 32'hbfc0_0000) begin bad++; $display("FAIL rmid_fetch_addr got=%h want=bfc00000", a); end
        total++; if (o_inst !== 32'h6666_0000) begin bad++; $display("FAIL rmid_fetch_inst got=%h want=66660000", o_inst); end
        handoff();
    endtask

    task automatic test_wrap();
        logic [31:0] a;
        bit ok;
        jpc = 32'hffff_fffc;
        do_fetch(32'h7777_0004, 1'b1, 2'b11, a, ok);
        total++; if (a !== 32'hbfc0_0004) begin bad++; $display("FAIL wrap_ds_addr got=%h want=bfc00004", a); end
        handoff();
        total++; if (inst_addr !== 32'hffff_fffc) begin bad++; $display("FAIL wrap_jpc_addr got=%h want=fffffffc", inst_addr); end
        // pcsource 00 with br_valid must not move the PC
        bpc = 32'h1234_5670;
        jrpc = 32'h1234_5674;
        jpc = 32'h1234_5678;
        do_fetch(32'h7777_fffc, 1'b1, 2'b00, a, ok);
        total++; if (a !== 32'hffff_fffc) begin bad++; $display("FAIL wrap_top_addr got=%h want=fffffffc", a); end
        total++; if (o_pc !== 32'hffff_fffc) begin bad++; $display("FAIL wrap_top_o_pc got=%h want=fffffffc", o_pc); end
        handoff();
        total++; if (inst_addr !== 32'h0000_0000) begin bad++; $display("FAIL wrap_next_addr got=%h want=00000000", inst_addr); end
    endtask

    task automatic test_adel();
        logic [31:0] a;
        bit ok;
        jrpc = 32'h8000_0042;
        do_fetch(32'h8888_0000, 1'b1, 2'b10, a, ok);
        total++; if (a !== 32'h0000_0000) begin bad++; $display("FAIL adel_ds_addr got=%h want=00000000", a); end
        handoff();
`ifdef IF_EXC_EN
        total++; if (inst_req !== 1'b0) begin bad++; $display("FAIL adel_no_req got=%b want=0", inst_req); end
        @(negedge clk);
        total++; if (inst_req !== 1'b0) begin bad++; $display("FAIL adel_no_req2 got=%b want=0", inst_req); end
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL adel_valid got=%b want=1", o_valid); end
        total++; if (o_adel !== 1'b1) begin bad++; $display("FAIL adel_flag got=%b want=1", o_adel); end
        total++; if (o_inst !== 32'h0) begin bad++; $display("FAIL adel_inst got=%h want=0", o_inst); end
        total++; if (o_pc !== 32'h8000_0042) begin bad++; $display("FAIL adel_o_pc got=%h want=80000042", o_pc); end
        $display("adel raised o_pc=%h", o_pc);
        handoff();
        total++; if (o_adel !== 1'b0) begin bad++; $display("FAIL adel_clear got=%b want=0", o_adel); end
`else
        total++; if (inst_req !== 1'b1) begin bad++; $display("FAIL mis_req got=%b want=1", inst_req); end
        total++; if (inst_addr !== 32'h8000_0042) begin bad++; $display("FAIL mis_addr got=%h want=80000042", inst_addr); end
        do_fetch(32'h9999_0042, 1'b0, 2'b00, a, ok);
        total++; if (a !== 32'h8000_0042) begin bad++; $display("FAIL mis_fetch_addr got=%h want=80000042", a); end
        total++; if (o_pc !== 32'h8000_0042) begin bad++; $display("FAIL mis_o_pc got=%h want=80000042", o_pc); end
        total++; if (o_adel !== 1'b0) begin bad++; $display("FAIL mis_adel got=%b want=0", o_adel); end
        handoff();
        total++; if (inst_addr !== 32'h8000_0046) begin bad++; $display("FAIL mis_next_addr got=%h want=80000046", inst_addr); end
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch_early();
        test_branch_late();
        test_reset_mid();
        test_wrap();
        test_adel();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
